// File: rtl/lbist_ctrl_multi.sv
// Multi-chain logic-BIST controller: LFSR stimulus into N scan chains, MISR compaction of
// scan-out data, and a final signature compare (or readout) at the end of the run.
module lbist_ctrl_multi #(
   parameter int                N_CHAINS   = 8,
   parameter int                CHAIN_LEN  = 16,
   parameter int                N_PATTERNS = 1024,
   parameter int                LFSR_W     = 32,
   parameter logic [LFSR_W-1:0] LFSR_POLY  = LFSR_W'(32'h80200003),
   parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(32'h00000001),
   parameter int                MISR_W     = 32,
   parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(32'h80200003),
   parameter logic [MISR_W-1:0] GOLDEN_SIG = MISR_W'(32'h0),
   localparam int               PC_W       = $clog2(N_PATTERNS + 1),
   localparam int               SC_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                test_mode_i,
   input  logic                start_i,
   input  logic                readout_mode_i,
   input  logic [N_CHAINS-1:0] scan_out_i,
   output logic                scan_en_o,
   output logic [N_CHAINS-1:0] scan_in_o,
   output logic                capture_o,
   output logic                test_mode_tp_o,
   output logic                busy_o,
   output logic                test_over_o,
   output logic                go_nogo_o,
   output logic [MISR_W-1:0]   signature_o,
   output logic [PC_W-1:0]     pattern_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [MISR_W-1:0] misr_q, misr_d, misr_step, scan_out_ext;
   logic [MISR_W-1:0] signature_q, signature_d;
   logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
   logic [PC_W-1:0]   pattern_cnt_q, pattern_cnt_d;
   logic              scan_en_q, scan_en_d;
   logic              capture_q, capture_d;
   logic              busy_q, busy_d;
   logic              test_over_q, test_over_d;
   logic              go_nogo_q, go_nogo_d;
   logic              last_shift;

   always_comb begin
      scan_out_ext                 = '0;
      scan_out_ext[N_CHAINS-1:0]   = scan_out_i;
      lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
      misr_step  = ((misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0)) ^ scan_out_ext;
      last_shift = (shift_cnt_q == SC_W'(CHAIN_LEN - 1));
   end

   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      misr_d        = misr_q;
      shift_cnt_d   = shift_cnt_q;
      pattern_cnt_d = pattern_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && test_mode_i) state_d = S_SEED;
         end
         S_SEED: begin
            lfsr_d        = LFSR_SEED;
            misr_d        = '0;
            shift_cnt_d   = '0;
            pattern_cnt_d = '0;
            state_d       = S_SHIFT;
         end
         S_SHIFT: begin
            lfsr_d      = lfsr_step;
            // The very first unload carries uninitialised chain contents, so it is not compacted.
            if (pattern_cnt_q != '0) misr_d = misr_step;
            shift_cnt_d = last_shift ? '0 : shift_cnt_q + SC_W'(1);
            if (last_shift) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            pattern_cnt_d = pattern_cnt_q + PC_W'(1);
            state_d       = (pattern_cnt_d == PC_W'(N_PATTERNS)) ? S_UNLOAD : S_SHIFT;
         end
         S_UNLOAD: begin
            lfsr_d      = lfsr_step;
            misr_d      = misr_step;
            shift_cnt_d = last_shift ? '0 : shift_cnt_q + SC_W'(1);
            if (last_shift) state_d = S_COMPARE;
         end
         S_COMPARE: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!test_mode_i)  state_d = S_IDLE;
            else if (start_i)  state_d = S_SEED;
         end
         default: state_d = S_IDLE;
      endcase
      if (!test_mode_i && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
   end

   // Strobes are registered from the next state so they line up exactly with state_q.
   always_comb begin
      scan_en_d   = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
      capture_d   = (state_d == S_CAPTURE);
      busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
      test_over_d = (state_d == S_DONE);
      signature_d = signature_q;
      go_nogo_d   = 1'b0;
      if (state_q == S_COMPARE && state_d == S_DONE) begin
         signature_d = misr_q;
         go_nogo_d   = (misr_q == GOLDEN_SIG) && !readout_mode_i;
      end else if (state_d == S_DONE) begin
         go_nogo_d   = go_nogo_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         lfsr_q        <= LFSR_SEED;
         misr_q        <= '0;
         shift_cnt_q   <= '0;
         pattern_cnt_q <= '0;
         signature_q   <= '0;
         scan_en_q     <= 1'b0;
         capture_q     <= 1'b0;
         busy_q        <= 1'b0;
         test_over_q   <= 1'b0;
         go_nogo_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         misr_q        <= misr_d;
         shift_cnt_q   <= shift_cnt_d;
         pattern_cnt_q <= pattern_cnt_d;
         signature_q   <= signature_d;
         scan_en_q     <= scan_en_d;
         capture_q     <= capture_d;
         busy_q        <= busy_d;
         test_over_q   <= test_over_d;
         go_nogo_q     <= go_nogo_d;
      end
   end

   // Chain inputs are gated so the pins stay quiet outside shifting.
   assign scan_in_o      = scan_en_q ? lfsr_q[N_CHAINS-1:0] : '0;
   assign scan_en_o      = scan_en_q;
   assign capture_o      = capture_q;
   assign test_mode_tp_o = busy_q;
   assign busy_o         = busy_q;
   assign test_over_o    = test_over_q;
   assign go_nogo_o      = go_nogo_q;
   assign signature_o    = signature_q;
   assign pattern_cnt_o  = pattern_cnt_q;

endmodule

// File: tb/tb_lbist_ctrl_multi.sv
// Bench for lbist_ctrl_multi in a small configuration: table-driven runs, hand-written
// reset/abort sequences and randomised runs checked against a cycle-timeline reference model.
module tb_lbist_ctrl_multi;

   localparam int          NCH    = 4;
   localparam int          CL     = 2;
   localparam int          NP     = 2;
   localparam logic [31:0] POLY   = 32'h80200003;
   localparam logic [31:0] SEED   = 32'h00000001;
   localparam logic [31:0] GOLDEN = 32'h0;
   localparam int          LAT    = 2 + NP * (CL + 1) + CL;
   localparam int          PCW    = $clog2(NP + 1);

   localparam int PH_SEED = 0, PH_SHIFT = 1, PH_CAP = 2, PH_UNLOAD = 3, PH_CMP = 4, PH_DONE = 5;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             test_mode_i = 1'b0;
   logic             start_i = 1'b0;
   logic             readout_mode_i = 1'b0;
   logic [NCH-1:0]   scan_out_i = '0;
   logic             scan_en_o, capture_o, test_mode_tp_o, busy_o, test_over_o, go_nogo_o;
   logic [NCH-1:0]   scan_in_o;
   logic [31:0]      signature_o;
   logic [PCW-1:0]   pattern_cnt_o;

   int chk_total = 0;
   int chk_pass  = 0;
   int run_no    = 0;
   logic [NCH-1:0] comp_q[$];

   always #5 clk = ~clk;

   lbist_ctrl_multi #(
      .N_CHAINS(NCH), .CHAIN_LEN(CL), .N_PATTERNS(NP), .GOLDEN_SIG(GOLDEN)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .test_mode_i(test_mode_i), .start_i(start_i),
      .readout_mode_i(readout_mode_i), .scan_out_i(scan_out_i),
      .scan_en_o(scan_en_o), .scan_in_o(scan_in_o), .capture_o(capture_o),
      .test_mode_tp_o(test_mode_tp_o), .busy_o(busy_o), .test_over_o(test_over_o),
      .go_nogo_o(go_nogo_o), .signature_o(signature_o), .pattern_cnt_o(pattern_cnt_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_total++;
      if (act === exp) chk_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lfsr_after(input int steps);
      logic [31:0] x = SEED;
      for (int i = 0; i < steps; i++) x = (x >> 1) ^ (x[0] ? POLY : 32'h0);
      return x;
   endfunction

   function automatic logic [31:0] misr_fold();
      logic [31:0] m = 32'h0;
      foreach (comp_q[i]) m = ((m >> 1) ^ (m[0] ? POLY : 32'h0)) ^ {28'h0, comp_q[i]};
      return m;
   endfunction

   // Where the run stands n edges after the start edge, from the schedule of the run.
   function automatic int phase_of(input int n, output int p, output int k);
      int m, u;
      p = 0; k = 0;
      if (n == 0) return PH_SEED;
      m = n - 1;
      if (m < NP * (CL + 1)) begin
         p = m / (CL + 1);
         k = m % (CL + 1);
         return (k < CL) ? PH_SHIFT : PH_CAP;
      end
      u = m - NP * (CL + 1);
      if (u < CL)  return PH_UNLOAD;
      if (u == CL) return PH_CMP;
      return PH_DONE;
   endfunction

   // {scan_en, capture, busy, test_mode_tp, test_over}
   function automatic logic [4:0] ctl_of(input int ph);
      case (ph)
         PH_SEED:   return 5'b00110;
         PH_SHIFT:  return 5'b10110;
         PH_CAP:    return 5'b01110;
         PH_UNLOAD: return 5'b10110;
         PH_CMP:    return 5'b00110;
         default:   return 5'b00001;
      endcase
   endfunction

   // pat_mode: 0 zeros, 1 chain 0 high on first compacted cycle only, 2 random.
   // ro_mode: 0/1 constant readout_mode_i, 2 random every cycle.
   task automatic do_run(input int pat_mode, input int ro_mode,
                         output logic [31:0] sig, output logic go);
      int p, k, ph;
      logic first = 1'b1;
      logic ro_eff = 1'b0;
      logic [NCH-1:0] v;
      logic [31:0] lv, exp_sig;
      logic exp_go;
      comp_q.delete();
      if (ro_mode < 2) readout_mode_i = ro_mode[0];
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int n = 0; n <= LAT; n++) begin
         ph = phase_of(n, p, k);
         check($sformatf("ctl run%0d n%0d", run_no, n),
               {scan_en_o, capture_o, busy_o, test_mode_tp_o, test_over_o}, ctl_of(ph));
         if (ph == PH_SHIFT) begin
            lv = lfsr_after(p * CL + k);
            check($sformatf("scan_in run%0d n%0d", run_no, n), scan_in_o, lv[NCH-1:0]);
         end
         if (ph == PH_SHIFT || ph == PH_CAP)
            check($sformatf("pcnt run%0d n%0d", run_no, n), pattern_cnt_o, p);
         if (n == LAT) break;
         case (pat_mode)
            0:       v = '0;
            1:       v = first ? 4'b0001 : 4'b0000;
            default: v = NCH'($urandom);
         endcase
         scan_out_i = v;
         if ((ph == PH_SHIFT && p > 0) || ph == PH_UNLOAD) begin
            comp_q.push_back(v);
            first = 1'b0;
         end
         if (ro_mode == 2) readout_mode_i = $urandom_range(0, 1) == 1;
         if (ph == PH_CMP) ro_eff = readout_mode_i;
         tick();
      end
      exp_sig = misr_fold();
      exp_go  = (exp_sig == GOLDEN) && !ro_eff;
      check($sformatf("signature run%0d", run_no), signature_o, exp_sig);
      check($sformatf("go_nogo run%0d", run_no), go_nogo_o, exp_go);
      check($sformatf("pcnt_done run%0d", run_no), pattern_cnt_o, NP);
      $display("run %0d: pat=%0d ro=%0d sig=%08h go=%0b exp_sig=%08h exp_go=%0b",
               run_no, pat_mode, ro_mode, signature_o, go_nogo_o, exp_sig, exp_go);
      sig = signature_o;
      go  = go_nogo_o;
      run_no++;
   endtask

   typedef struct {
      int          pat_mode;
      int          ro_mode;
      logic [31:0] exp_sig;
      logic        exp_go;
   } vec_t;

   initial begin
      vec_t        tbl[5];
      logic [31:0] sig;
      logic        go;

      tbl[0] = '{0, 0, 32'h00000000, 1'b1};
      tbl[1] = '{1, 0, 32'h60180001, 1'b0};
      tbl[2] = '{1, 1, 32'h60180001, 1'b0};
      tbl[3] = '{0, 1, 32'h00000000, 1'b0};
      tbl[4] = '{1, 0, 32'h60180001, 1'b0};

      // Reset state
      repeat (3) tick();
      check("reset_ctl", {scan_en_o, capture_o, busy_o, test_mode_tp_o, test_over_o,
                          go_nogo_o, scan_in_o}, 0);
      check("reset_sig", signature_o, 0);
      check("reset_pcnt", pattern_cnt_o, 0);
      rst_i = 1'b0;
      test_mode_i = 1'b1;
      tick();
      check("idle_hold", busy_o, 0);
      $display("reset: outputs idle");

      // Reset mid-SHIFT, then a full normal run
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      check("mid_shift_scan_en", scan_en_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_mid_ctl", {scan_en_o, capture_o, busy_o, test_mode_tp_o, test_over_o,
                            go_nogo_o, scan_in_o}, 0);
      check("rst_mid_pcnt", pattern_cnt_o, 0);
      $display("reset mid-shift: outputs idle");
      do_run(0, 0, sig, go);

      // Table-driven runs; consecutive rows restart straight from DONE
      for (int i = 0; i < 5; i++) begin
         do_run(tbl[i].pat_mode, tbl[i].ro_mode, sig, go);
         check($sformatf("tbl%0d_sig", i), sig, tbl[i].exp_sig);
         check($sformatf("tbl%0d_go", i), go, tbl[i].exp_go);
      end

      // Abort during CAPTURE with start pulses ignored
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      scan_out_i = '0;
      repeat (3) tick();
      check("abort_at_capture", capture_o, 1);
      test_mode_i = 1'b0;
      start_i = 1'b1;
      tick();
      check("abort_ctl", {scan_en_o, capture_o, busy_o, test_mode_tp_o, test_over_o,
                          go_nogo_o}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("abort_start_ignored%0d", i), {busy_o, test_over_o}, 0);
      end
      check("abort_sig_kept", signature_o, 32'h60180001);
      start_i = 1'b0;
      test_mode_i = 1'b1;
      tick();
      check("abort_idle", busy_o, 0);
      $display("abort: controller idle, signature kept");

      // DONE exits to IDLE when test mode drops
      do_run(1, 0, sig, go);
      test_mode_i = 1'b0;
      tick();
      check("done_exit_ctl", {busy_o, test_over_o, go_nogo_o}, 0);
      check("done_exit_sig", signature_o, 32'h60180001);
      test_mode_i = 1'b1;
      tick();
      $display("done exit: idle, signature kept");

      // Randomised runs against the reference model
      for (int i = 0; i < 8; i++) do_run(2, 2, sig, go);

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
